// File: rtl/lbp_code_gen.sv
// Turns a centre pixel and its 8 circular neighbours into an LBP code, a uniformity
// flag and a riu2 label through three registered stages, and marks the last code of each frame.
module lbp_code_gen #(
  parameter logic [7:0]  THRESH       = 8'd0,
  parameter int unsigned FRAME_PIXELS = 16384,
  parameter int unsigned CNT_W        = 14
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         done_i,
  input  logic [7:0]   mid_i,
  input  logic [7:0]   S1_i,
  input  logic [7:0]   S2_i,
  input  logic [7:0]   S3_i,
  input  logic [7:0]   S4_i,
  input  logic [7:0]   S5_i,
  input  logic [7:0]   S6_i,
  input  logic [7:0]   S7_i,
  input  logic [7:0]   S8_i,
  output logic [7:0]   lbp_o,
  output logic         uniform_o,
  output logic [3:0]   riu2_o,
  output logic         done_o,
  output logic         frame_done_o
);

  function automatic logic at_or_above(input logic [7:0] s, input logic [8:0] t);
    return ({1'b0, s} >= t);
  endfunction

  function automatic logic [3:0] popcount8(input logic [7:0] x);
    logic [3:0] n;
    n = 4'd0;
    for (int k = 0; k < 8; k++) begin
      n = n + {3'd0, x[k]};
    end
    return n;
  endfunction

  // Threshold is formed at 9 bits so mid+THRESH above 255 can never be met by any sample.
  logic [8:0] thr;
  logic [7:0] cmp;

  assign thr = {1'b0, mid_i} + {1'b0, THRESH};
  assign cmp = {at_or_above(S8_i, thr), at_or_above(S7_i, thr),
                at_or_above(S6_i, thr), at_or_above(S5_i, thr),
                at_or_above(S4_i, thr), at_or_above(S3_i, thr),
                at_or_above(S2_i, thr), at_or_above(S1_i, thr)};

  logic [7:0] b1;
  logic       v1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      b1 <= 8'd0;
      v1 <= 1'b0;
    end else begin
      b1 <= cmp;
      v1 <= done_i;
    end
  end

  // Circular transitions: each bit against its neighbour one position further round.
  logic [7:0] rot1;
  logic [3:0] u_next;
  logic [3:0] p_next;

  assign rot1   = {b1[0], b1[7:1]};
  assign u_next = popcount8(b1 ^ rot1);
  assign p_next = popcount8(b1);

  logic [7:0] b2;
  logic [3:0] u2;
  logic [3:0] p2;
  logic       v2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      b2 <= 8'd0;
      u2 <= 4'd0;
      p2 <= 4'd0;
      v2 <= 1'b0;
    end else begin
      b2 <= b1;
      u2 <= u_next;
      p2 <= p_next;
      v2 <= v1;
    end
  end

  logic             uni2;
  logic [CNT_W-1:0] frame_cnt;
  logic             last_in_frame;

  assign uni2          = (u2 <= 4'd2);
  assign last_in_frame = (frame_cnt == CNT_W'(FRAME_PIXELS - 1));

  // Output registers hold their last code across bubbles; only the strobes drop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lbp_o        <= 8'd0;
      uniform_o    <= 1'b0;
      riu2_o       <= 4'd0;
      done_o       <= 1'b0;
      frame_done_o <= 1'b0;
      frame_cnt    <= '0;
    end else begin
      done_o       <= v2;
      frame_done_o <= 1'b0;
      if (v2) begin
        lbp_o        <= b2;
        uniform_o    <= uni2;
        riu2_o       <= uni2 ? p2 : 4'd9;
        frame_done_o <= last_in_frame;
        frame_cnt    <= last_in_frame ? '0 : frame_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_lbp_code_gen.sv
// Directed bench for lbp_code_gen: a THRESH=0 / 4-pixel-frame instance and a
// THRESH=10 / 1-pixel-frame instance share the same stimulus.
module tb_lbp_code_gen;
  localparam int NV  = 9;
  localparam int FP0 = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       done_i = 1'b0;
  logic [7:0] mid_i = 8'd0;
  logic [7:0] S1_i = 8'd0, S2_i = 8'd0, S3_i = 8'd0, S4_i = 8'd0;
  logic [7:0] S5_i = 8'd0, S6_i = 8'd0, S7_i = 8'd0, S8_i = 8'd0;

  logic [7:0] lbp0, lbp1;
  logic       uni0, uni1;
  logic [3:0] riu0, riu1;
  logic       done0, done1;
  logic       fd0, fd1;

  lbp_code_gen #(.THRESH(8'd0), .FRAME_PIXELS(FP0), .CNT_W(2)) dut0 (
    .clk(clk), .rst(rst), .done_i(done_i), .mid_i(mid_i),
    .S1_i(S1_i), .S2_i(S2_i), .S3_i(S3_i), .S4_i(S4_i),
    .S5_i(S5_i), .S6_i(S6_i), .S7_i(S7_i), .S8_i(S8_i),
    .lbp_o(lbp0), .uniform_o(uni0), .riu2_o(riu0), .done_o(done0), .frame_done_o(fd0)
  );

  lbp_code_gen #(.THRESH(8'd10), .FRAME_PIXELS(1), .CNT_W(1)) dut1 (
    .clk(clk), .rst(rst), .done_i(done_i), .mid_i(mid_i),
    .S1_i(S1_i), .S2_i(S2_i), .S3_i(S3_i), .S4_i(S4_i),
    .S5_i(S5_i), .S6_i(S6_i), .S7_i(S7_i), .S8_i(S8_i),
    .lbp_o(lbp1), .uniform_o(uni1), .riu2_o(riu1), .done_o(done1), .frame_done_o(fd1)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  mid;
    logic [63:0] s;
    logic [7:0]  lbp0;
    logic        uni0;
    logic [3:0]  riu0;
    logic [7:0]  lbp1;
    logic        uni1;
    logic [3:0]  riu1;
  } vec_t;

  vec_t vecs [NV];

  int n_checks = 0;
  int n_errors = 0;
  int fc = 0;
  logic [7:0] e_l0, e_l1;
  logic       e_u0, e_u1;
  logic [3:0] e_r0, e_r1;

  function automatic vec_t mk(input logic [7:0] mid,
                              input logic [7:0] s1, s2, s3, s4, s5, s6, s7, s8,
                              input logic [7:0] l0, input logic u0, input logic [3:0] r0,
                              input logic [7:0] l1, input logic u1, input logic [3:0] r1);
    vec_t v;
    v.mid  = mid;
    v.s    = {s8, s7, s6, s5, s4, s3, s2, s1};
    v.lbp0 = l0; v.uni0 = u0; v.riu0 = r0;
    v.lbp1 = l1; v.uni1 = u1; v.riu1 = r1;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, req, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input int i);
    vec_t t;
    done_i = v;
    if (v) begin
      t = vecs[i];
      mid_i = t.mid;
      S1_i = t.s[7:0];   S2_i = t.s[15:8];  S3_i = t.s[23:16]; S4_i = t.s[31:24];
      S5_i = t.s[39:32]; S6_i = t.s[47:40]; S7_i = t.s[55:48]; S8_i = t.s[63:56];
    end else begin
      // Junk that would decode to 0xFF if it ever leaked through a bubble.
      mid_i = 8'd0;
      {S1_i, S2_i, S3_i, S4_i, S5_i, S6_i, S7_i, S8_i} = {8{8'd255}};
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, " lbp_o"}, int'(lbp0), 0);
    chk({tag, " uniform_o"}, int'(uni0), 0);
    chk({tag, " riu2_o"}, int'(riu0), 0);
    chk({tag, " done_o"}, int'(done0), 0);
    chk({tag, " frame_done_o"}, int'(fd0), 0);
    chk({tag, " dut1 lbp_o"}, int'(lbp1), 0);
    chk({tag, " dut1 done_o"}, int'(done1), 0);
  endtask

  task automatic do_reset();
    done_i = 1'b0;
    #2 rst = 1'b1;
    #1 check_zero("reset");
    #1 rst = 1'b0;
    fc = 0;
    e_l0 = 8'd0; e_u0 = 1'b0; e_r0 = 4'd0;
    e_l1 = 8'd0; e_u1 = 1'b0; e_r1 = 4'd0;
  endtask

  // Drive pat[0..len-1] one bit per cycle; expect the same pattern 3 cycles later.
  task automatic stream(input logic [31:0] pat, input int len, input int vbase);
    int   ed [40];
    int   ev [40];
    int   ns;
    int   idx;
    logic efd;
    ns = 0;
    for (int c = 0; c < len + 3; c++) begin
      if (c < len && pat[c]) begin
        ev[c] = (vbase + ns) % NV;
        ed[c] = 1;
        ns++;
        drive(1'b1, ev[c]);
      end else begin
        ev[c] = 0;
        ed[c] = 0;
        drive(1'b0, 0);
      end
      tick();
      idx = c - 2;
      if (idx >= 0) begin
        efd = 1'b0;
        if (ed[idx] == 1) begin
          e_l0 = vecs[ev[idx]].lbp0; e_u0 = vecs[ev[idx]].uni0; e_r0 = vecs[ev[idx]].riu0;
          e_l1 = vecs[ev[idx]].lbp1; e_u1 = vecs[ev[idx]].uni1; e_r1 = vecs[ev[idx]].riu1;
          efd = (fc == FP0 - 1);
          fc = (fc + 1) % FP0;
        end
        chk("done_o", int'(done0), ed[idx]);
        chk("frame_done_o", int'(fd0), int'(efd));
        chk("lbp_o", int'(lbp0), int'(e_l0));
        chk("uniform_o", int'(uni0), int'(e_u0));
        chk("riu2_o", int'(riu0), int'(e_r0));
        chk("thr10 done_o", int'(done1), ed[idx]);
        chk("fp1 frame_done_o", int'(fd1), ed[idx]);
        chk("thr10 lbp_o", int'(lbp1), int'(e_l1));
        chk("thr10 uniform_o", int'(uni1), int'(e_u1));
        chk("thr10 riu2_o", int'(riu1), int'(e_r1));
      end
    end
  endtask

  initial begin
    //              mid  S1   S2   S3   S4   S5   S6   S7   S8    thr0: lbp u riu  thr10: lbp u riu
    vecs[0] = mk(100, 120, 130,  90,  80,  70,  60, 110, 105, 8'hC3, 1, 4, 8'h43, 0, 9);
    vecs[1] = mk( 50,  60,  40,  60,  40,  60,  40,  60,  40, 8'h55, 0, 9, 8'h55, 0, 9);
    vecs[2] = mk(250, 255, 255, 255, 255, 255, 255, 255, 255, 8'hFF, 1, 8, 8'h00, 1, 0);
    vecs[3] = mk( 77,  77,  77,  77,  77,  77,  77,  77,  77, 8'hFF, 1, 8, 8'h00, 1, 0);
    vecs[4] = mk(200,  10,  10,  10,  10,  10,  10,  10,  10, 8'h00, 1, 0, 8'h00, 1, 0);
    vecs[5] = mk(  0,   0,   0,   0,   0,   0,   0,   0,   0, 8'hFF, 1, 8, 8'h00, 1, 0);
    vecs[6] = mk(128,   0,   0,   0, 200, 200, 200,   0,   0, 8'h38, 1, 3, 8'h38, 1, 3);
    vecs[7] = mk(128, 127, 128, 129,   0, 255,   0,   0,   0, 8'h16, 0, 9, 8'h10, 1, 1);
    vecs[8] = mk( 10,   9,   9,   9,   9,   9,   9,   9,  20, 8'h80, 1, 1, 8'h80, 1, 1);

    do_reset();
    tick();

    // Isolated single samples, one per table entry; the frame count runs across them.
    for (int i = 0; i < NV; i++) begin
      stream(32'b1, 1, i);
    end

    // Bubbles: 1,1,0,1,0,0,1
    do_reset();
    stream(32'b1001011, 7, 0);

    // Frame wrap: 9 back-to-back, a 2-cycle gap, then 3 more; the 12th closes a frame.
    do_reset();
    stream(32'b11100111111111, 14, 2);

    // Async reset with two samples in flight.
    do_reset();
    stream(32'b11, 2, 1);
    drive(1'b1, 0);
    tick();
    drive(1'b1, 6);
    tick();
    drive(1'b0, 0);
    #3 rst = 1'b1;
    #1 check_zero("async reset");
    #1 rst = 1'b0;
    fc = 0;
    e_l0 = 8'd0; e_u0 = 1'b0; e_r0 = 4'd0;
    e_l1 = 8'd0; e_u1 = 1'b0; e_r1 = 4'd0;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("flushed done_o", int'(done0), 0);
      chk("flushed lbp_o", int'(lbp0), 0);
      chk("flushed thr10 done_o", int'(done1), 0);
    end
    stream(32'b1111, 4, 6);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
